jtframe_vtimer_prog: RTL



---
 rtl/jtframe_vtimer_pkg.sv | 38 +++
 rtl/jtframe_vtimer_shadow.sv | 54 +++++
 rtl/jtframe_vtimer_prog.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jtframe_vtimer_pkg.sv
// Register map and default raster timing for the programmable video timer.
// Defining JTFRAME_VTIMER_LINEIRQ_EN adds the IRQ_LINE register at address 10.
package jtframe_vtimer_pkg;

  localparam logic [3:0] A_HB_END   = 4'd0;
  localparam logic [3:0] A_HB_START = 4'd1;
  localparam logic [3:0] A_HS_START = 4'd2;
  localparam logic [3:0] A_HS_END   = 4'd3;
  localparam logic [3:0] A_HCNT_END = 4'd4;
  localparam logic [3:0] A_VB_START = 4'd5;
  localparam logic [3:0] A_VB_END   = 4'd6;
  localparam logic [3:0] A_VS_START = 4'd7;
  localparam logic [3:0] A_VS_END   = 4'd8;
  localparam logic [3:0] A_VCNT_END = 4'd9;
  localparam logic [3:0] A_IRQ_LINE = 4'd10;

`ifdef JTFRAME_VTIMER_LINEIRQ_EN
  localparam int NREG = 11;
`else
  localparam int NREG = 10;
`endif

  localparam int DEF_HB_END   = 8;
  localparam int DEF_HB_START = 264;
  localparam int DEF_HS_START = 304;
  localparam int DEF_HS_END   = 336;
  localparam int DEF_HCNT_END = 383;
  localparam int DEF_VB_START = 256;
  localparam int DEF_VB_END   = 0;
  localparam int DEF_VS_START = 264;
  localparam int DEF_VS_END   = 270;
  localparam int DEF_VCNT_END = 283;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jtframe_vtimer_shadow.sv
// Shadow/active timing register bank; shadow copies to active on apply_i.
// Register count follows JTFRAME_VTIMER_LINEIRQ_EN through the package.
module jtframe_vtimer_shadow
  import jtframe_vtimer_pkg::*;
#(
  parameter int HW = 9,
  parameter int VW = 9,
  parameter int DW = 9,
  parameter logic [NREG-1:0][DW-1:0] DEFAULTS = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     apply_i,
  input  logic                     cfg_we_i,
  input  logic [3:0]               cfg_addr_i,
  input  logic [DW-1:0]            cfg_din_i,
  output logic                     cfg_pending_o,
  output logic [NREG-1:0][DW-1:0]  cur_o
);

  logic [NREG-1:0][DW-1:0] shadow_q, shadow_d, active_q;
  logic                    pending_q, pending_d;
  logic                    wr_ok;
  logic [DW-1:0]           wr_val;

  assign wr_ok  = cfg_we_i && (cfg_addr_i < 4'(NREG));
  assign wr_val = (cfg_addr_i <= A_HCNT_END) ? DW'(cfg_din_i[HW-1:0])
                                             : DW'(cfg_din_i[VW-1:0]);

  // cur_o already shows the freshly applied values on the apply edge itself
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      assign shadow_d[gi] = (wr_ok && cfg_addr_i == 4'(gi)) ? wr_val : shadow_q[gi];
      assign cur_o[gi]    = apply_i ? shadow_d[gi] : active_q[gi];
    end
  endgenerate

  assign pending_d     = apply_i ? wr_ok : (pending_q | wr_ok);
  assign cfg_pending_o = pending_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q  <= DEFAULTS;
      active_q  <= DEFAULTS;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      if (apply_i) active_q <= shadow_d;
    end
  end

endmodule

// File: rtl/jtframe_vtimer_prog.sv
// Programmable video timer: H/V counters, blanking/sync and reconfigurable timing.
// JTFRAME_VTIMER_LINEIRQ_EN enables the line interrupt (line_irq/irq_ack).
module jtframe_vtimer_prog
  import jtframe_vtimer_pkg::*;
#(
  parameter int HW       = 9,
  parameter int VW       = 9,
  parameter int HB_END   = DEF_HB_END,
  parameter int HB_START = DEF_HB_START,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END   = DEF_HS_END,
  parameter int HCNT_END = DEF_HCNT_END,
  parameter int VB_START = DEF_VB_START,
  parameter int VB_END   = DEF_VB_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END   = DEF_VS_END,
  parameter int VCNT_END = DEF_VCNT_END,
  localparam int DW      = imax(HW, VW)
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_addr,
  input  logic [DW-1:0] cfg_din,
  output logic          cfg_pending,
  output logic [HW-1:0] H,
  output logic [VW-1:0] vdump,
  output logic [VW-1:0] vrender,
  output logic          Hinit,
  output logic          Vinit,
  output logic          LHBL,
  output logic          LVBL,
  output logic          HS,
  output logic          VS,
  output logic          line_irq,
  input  logic          irq_ack
);

  localparam logic [NREG-1:0][DW-1:0] DEFAULTS = {
`ifdef JTFRAME_VTIMER_LINEIRQ_EN
    DW'(0),
`endif
    DW'(VCNT_END), DW'(VS_END), DW'(VS_START), DW'(VB_END), DW'(VB_START),
    DW'(HCNT_END), DW'(HS_END), DW'(HS_START), DW'(HB_START), DW'(HB_END)};

  logic [NREG-1:0][DW-1:0] cur;
  logic                    apply, h_wrap, v_last;
  logic [HW-1:0]           h_q, h_d;
  logic [VW-1:0]           v_q, v_d, vr_q;
  logic                    hinit_q, vinit_q, lhbl_q, lvbl_q, hs_q, vs_q;
  logic [HW-1:0]           hb_end, hb_start, hs_start, hs_end, hcnt_end;
  logic [VW-1:0]           vb_start, vb_end, vs_start, vs_end, vcnt_end;

  jtframe_vtimer_shadow #(
    .HW(HW), .VW(VW), .DW(DW), .DEFAULTS(DEFAULTS)
  ) u_shadow (
    .clk_i        (clk),
    .rst_i        (rst),
    .apply_i      (apply),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_din_i    (cfg_din),
    .cfg_pending_o(cfg_pending),
    .cur_o        (cur)
  );

  assign hb_end   = cur[A_HB_END][HW-1:0];
  assign hb_start = cur[A_HB_START][HW-1:0];
  assign hs_start = cur[A_HS_START][HW-1:0];
  assign hs_end   = cur[A_HS_END][HW-1:0];
  assign hcnt_end = cur[A_HCNT_END][HW-1:0];
  assign vb_start = cur[A_VB_START][VW-1:0];
  assign vb_end   = cur[A_VB_END][VW-1:0];
  assign vs_start = cur[A_VS_START][VW-1:0];
  assign vs_end   = cur[A_VS_END][VW-1:0];
  assign vcnt_end = cur[A_VCNT_END][VW-1:0];

  // The apply edge is always the frame wrap, whatever the new end values are
  assign apply  = pxl_cen & vinit_q & cfg_pending;
  assign h_wrap = apply | (h_q == hcnt_end);
  assign v_last = apply | (v_q == vcnt_end);
  assign h_d    = h_wrap ? '0 : h_q + 1'b1;
  assign v_d    = !h_wrap ? v_q : (v_last ? '0 : v_q + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      vr_q    <= VW'(1);
      hinit_q <= 1'b0;
      vinit_q <= 1'b0;
      lhbl_q  <= 1'b0;
      lvbl_q  <= 1'b1;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else if (pxl_cen) begin
      h_q     <= h_d;
      v_q     <= v_d;
      vr_q    <= (v_d == vcnt_end) ? '0 : v_d + 1'b1;
      hinit_q <= (h_d == hcnt_end);
      vinit_q <= (h_d == hcnt_end) && (v_d == vcnt_end);
      if (h_d == hb_start) lhbl_q <= 1'b0;
      if (h_d == hb_end)   lhbl_q <= 1'b1;
      if (h_d == hs_start) hs_q   <= 1'b1;
      if (h_d == hs_end)   hs_q   <= 1'b0;
      if (h_wrap) begin
        if (v_d == vb_start) lvbl_q <= 1'b0;
        if (v_d == vb_end)   lvbl_q <= 1'b1;
        if (v_d == vs_start) vs_q   <= 1'b1;
        if (v_d == vs_end)   vs_q   <= 1'b0;
      end
    end
  end

`ifdef JTFRAME_VTIMER_LINEIRQ_EN
  logic irq_q;

  // A new line event wins over a simultaneous acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 irq_q <= 1'b0;
    else if (pxl_cen && h_wrap && v_d == cur[A_IRQ_LINE][VW-1:0]) irq_q <= 1'b1;
    else if (irq_ack)                                        irq_q <= 1'b0;
  end
  assign line_irq = irq_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign line_irq       = 1'b0;
`endif

  assign H       = h_q;
  assign vdump   = v_q;
  assign vrender = vr_q;
  assign Hinit   = hinit_q;
  assign Vinit   = vinit_q;
  assign LHBL    = lhbl_q;
  assign LVBL    = lvbl_q;
  assign HS      = hs_q;
  assign VS      = vs_q;

endmodule
